// File: rtl/image_pkg.sv
// Shared constants and read-side FSM state type for the image filter RAM path.
package image_pkg;

    localparam int unsigned IMG_WIDTH  = 64;
    localparam int unsigned IMG_ROWS   = 49;
    localparam int unsigned IMG_ADDR_W = 7;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StLoad,
        StShift,
        StDone
    } rd_state_t;

endpackage

// File: rtl/row_serializer.sv
// Holds one RAM word and shifts it out LSB-first, tracking the column of the
// pixel currently presented.
module row_serializer
    import image_pkg::*;
#(
    parameter int unsigned WIDTH = IMG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             ready,
    output logic             pix_data,
    output logic             sol,
    output logic             eol,
    output logic             last_beat
);

    localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_shreg;
    logic [COL_W-1:0] r_col;
    logic             w_eol;

    // ready is the accepted handshake, so state only moves on a consumed beat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shreg <= '0;
            r_col   <= '0;
        end else if (load) begin
            r_shreg <= word;
            r_col   <= '0;
        end else if (ready) begin
            r_shreg <= r_shreg >> 1;
            r_col   <= r_col + COL_W'(1);
        end
    end

    assign w_eol     = (r_col == COL_W'(WIDTH - 1));
    assign pix_data  = r_shreg[0];
    assign sol       = (r_col == '0);
    assign eol       = w_eol;
    assign last_beat = w_eol & ready;

endmodule

// File: rtl/image_row_reader.sv
// Fetches ROWS words from the result RAM and streams them as row-framed
// serial pixels with valid/ready flow control.
module image_row_reader
    import image_pkg::*;
#(
    parameter int unsigned WIDTH  = IMG_WIDTH,
    parameter int unsigned ROWS   = IMG_ROWS,
    parameter int unsigned ADDR_W = IMG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  ramdata,
    output logic [ADDR_W-1:0] ramaddress,
    output logic              read_request,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_data,
    output logic              sol,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic              done
);

    rd_state_t         r_state;
    logic [ADDR_W-1:0] r_row;
    logic              r_rd_req;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    logic w_hs;
    logic w_load;
    logic w_last_row;
    logic w_pix;
    logic w_sol;
    logic w_eol;
    logic w_last_beat;

    assign w_hs       = r_valid & pix_ready;
    assign w_load     = (r_state == StLoad);
    assign w_last_row = (r_row == ADDR_W'(ROWS - 1));

    row_serializer #(
        .WIDTH (WIDTH)
    ) u_row_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .word      (ramdata),
        .ready     (w_hs),
        .pix_data  (w_pix),
        .sol       (w_sol),
        .eol       (w_eol),
        .last_beat (w_last_beat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_row    <= '0;
            r_rd_req <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_row    <= '0;
                        r_rd_req <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= StReq;
                    end
                end
                StReq: begin
                    r_rd_req <= 1'b0;
                    r_state  <= StLoad;
                end
                StLoad: begin
                    r_valid <= 1'b1;
                    r_state <= StShift;
                end
                StShift: begin
                    if (w_last_beat) begin
                        r_valid <= 1'b0;
                        if (w_last_row) begin
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_row    <= r_row + ADDR_W'(1);
                            r_rd_req <= 1'b1;
                            r_state  <= StReq;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // The column counter idles at 0, so markers are only meaningful while valid.
    assign ramaddress   = r_row;
    assign read_request = r_rd_req;
    assign pix_valid    = r_valid;
    assign pix_data     = w_pix;
    assign sol          = w_sol & r_valid;
    assign eol          = w_eol & r_valid;
    assign eof          = w_eol & r_valid & w_last_row;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_image_row_reader.sv
// Self-checking bench: full-size reader against a frame model, plus an 8x2 instance.
module tb_image_row_reader;

    localparam int unsigned W  = 64;
    localparam int unsigned R  = 49;
    localparam int unsigned AW = 7;
    localparam int unsigned SW = 8;
    localparam int unsigned SR = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, start_s;
    logic [W-1:0]  ramdata;
    logic [AW-1:0] ramaddress;
    logic          read_request, pix_valid, pix_ready, pix_data, sol, eol, eof, busy, done;

    logic [SW-1:0] s_ramdata;
    logic [AW-1:0] s_ramaddress;
    logic          s_rreq, s_valid, s_ready, s_data, s_sol, s_eol, s_eof, s_busy, s_done;

    logic [W-1:0]  mem   [0:127];
    logic [SW-1:0] s_mem [0:127];

    bit ready_rand;
    int n_tests;
    int n_fail;

    image_row_reader #(.WIDTH(W), .ROWS(R), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .ramdata(ramdata), .ramaddress(ramaddress),
        .read_request(read_request), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .sol(sol), .eol(eol), .eof(eof), .busy(busy), .done(done)
    );

    image_row_reader #(.WIDTH(SW), .ROWS(SR), .ADDR_W(AW)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .ramdata(s_ramdata), .ramaddress(s_ramaddress),
        .read_request(s_rreq), .pix_valid(s_valid), .pix_ready(s_ready),
        .pix_data(s_data), .sol(s_sol), .eol(s_eol), .eof(s_eof), .busy(s_busy), .done(s_done)
    );

    // One-cycle-latency RAM models
    always @(posedge clk) begin
        if (read_request) ramdata <= mem[ramaddress];
        if (s_rreq) s_ramdata <= s_mem[s_ramaddress];
    end

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = ready_rand ? ($urandom_range(99) < 30) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {data, sol, eol, eof} of beat k of a frame.
    function automatic logic [3:0] model_beat(input int k);
        logic [6:0] r;
        logic [5:0] c;
        r = 7'(k / W);
        c = 6'(k % W);
        return {mem[r][c], (k % W) == 0, (k % W) == W - 1, k == R * W - 1};
    endfunction

    task automatic run_frame(input bit rand_ready, input int busy_beat, input int abort_beat,
                             input bit check_timing);
        int cnt, beats, nsol, neol, neof, nrreq, extra_done, extra_rreq;
        bit prev_stall, prev_eof_hs, pulsed, finished;
        logic [3:0] prev_out, got_o;
        ready_rand = rand_ready;
        beats = 0; nsol = 0; neol = 0; neof = 0; nrreq = 0;
        prev_stall = 0; prev_eof_hs = 0; pulsed = 0; finished = 0; prev_out = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 1;
        for (int guard = 0; guard < 40000 && !finished; guard++) begin
            cnt++;
            if (check_timing) begin
                if (cnt == 2) check("first_rreq", 64'({read_request, ramaddress}), 64'({1'b1, 7'd0}));
                if (cnt == 3) check("valid_in_load", 64'(pix_valid), 64'(0));
                if (cnt == 4) check("first_valid", 64'(pix_valid), 64'(1));
            end
            got_o = {pix_data, sol, eol, eof};
            if (prev_stall) check("stall_hold", 64'({pix_valid, got_o}), 64'({1'b1, prev_out}));
            if (abort_beat >= 0 && beats == abort_beat && pix_valid) begin
                rst = 1'b0;
                @(negedge clk);
                check("abort_outputs", 64'({ramaddress, read_request, pix_valid, pix_data, sol,
                      eol, eof, busy, done}), 64'(0));
                rst = 1'b1;
                extra_done = 0;
                for (int i = 0; i < 80; i++) begin
                    @(negedge clk);
                    extra_done += int'(done);
                end
                check("abort_no_done", 64'(extra_done), 64'(0));
                check("abort_idle", 64'({busy, pix_valid}), 64'(0));
                return;
            end
            if (read_request) begin
                check("rreq_addr", 64'(ramaddress), 64'(nrreq));
                nrreq++;
            end
            if (done || prev_eof_hs) check("done_after_eof", 64'(done), 64'(prev_eof_hs));
            prev_eof_hs = 0;
            if (pix_valid && pix_ready) begin
                check("beat", 64'(got_o), 64'(model_beat(beats)));
                nsol += int'(sol);
                neol += int'(eol);
                neof += int'(eof);
                prev_eof_hs = eof;
                beats++;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_out = got_o;
            if (busy_beat >= 0 && !pulsed && beats == busy_beat) begin
                start = 1'b1;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
            if (done) finished = 1;
            else @(negedge clk);
        end
        start = 1'b0;
        check("frame_finished", 64'(finished), 64'(1));
        check("beat_count", 64'(beats), 64'(R * W));
        check("sol_count", 64'(nsol), 64'(R));
        check("eol_count", 64'(neol), 64'(R));
        check("eof_count", 64'(neof), 64'(1));
        check("rreq_count", 64'(nrreq), 64'(R));
        if (check_timing && !rand_ready) check("frame_cycles", 64'(cnt), 64'(R * (W + 2) + 2));
        extra_done = 0;
        extra_rreq = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            extra_done += int'(done);
            extra_rreq += int'(read_request);
        end
        check("single_done", 64'(extra_done), 64'(0));
        check("no_restart", 64'(extra_rreq), 64'(0));
        check("idle_after_frame", 64'({busy, pix_valid}), 64'(0));
    endtask

    typedef struct {
        int   stall;
        logic data;
        logic sol;
        logic eol;
        logic eof;
    } vec_t;

    task automatic run_small();
        vec_t       vt [16];
        logic [7:0] wa, wb;
        int         w;
        wa = 8'hA5;
        wb = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            vt[i].stall = i % 3;
            vt[i].data  = (i < 8) ? wa[i] : wb[i - 8];
            vt[i].sol   = (i % 8) == 0;
            vt[i].eol   = (i % 8) == 7;
            vt[i].eof   = (i == 15);
        end
        s_mem[0] = wa;
        s_mem[1] = wb;
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_ready = 1'b0;
            repeat (vt[i].stall) @(negedge clk);
            s_ready = 1'b1;
            w = 0;
            while (!s_valid && w < 10) begin
                @(negedge clk);
                w++;
            end
            check("small_valid", 64'(s_valid), 64'(1));
            check("small_beat", 64'({s_data, s_sol, s_eol, s_eof}),
                  64'({vt[i].data, vt[i].sol, vt[i].eol, vt[i].eof}));
            @(negedge clk);
            s_ready = 1'b0;
        end
        check("small_done", 64'({s_done, s_valid}), 64'({1'b1, 1'b0}));
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        ready_rand = 0;
        s_ready = 1'b0;
        rst = 1'b0;
        start = 1'b1;
        start_s = 1'b1;
        for (int a = 0; a < 128; a++) begin
            mem[a] = 64'(a);
            s_mem[a] = '0;
        end
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", 64'({ramaddress, read_request, pix_valid, pix_data, sol, eol,
                  eof, busy, done}), 64'(0));
        end
        check("reset_small", 64'({s_rreq, s_valid, s_sol, s_eol, s_eof, s_busy, s_done}), 64'(0));
        start = 1'b0;
        start_s = 1'b0;
        rst = 1'b1;

        run_frame(0, -1, -1, 1);
        run_frame(1, -1, -1, 1);
        run_frame(0, 10 * W + 5, -1, 1);
        run_frame(0, -1, 20 * W + 33, 0);
        run_frame(0, -1, -1, 1);
        for (int a = 0; a < R; a++) mem[a] = {$urandom, $urandom};
        run_frame(1, -1, -1, 1);
        ready_rand = 0;
        run_small();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/image_row_reader.md
# image_row_reader

Reads filtered image rows back out of the result RAM and delivers them as a serial, row-framed pixel stream with valid/ready flow control. Rows are fetched one 64-bit word at a time from RAM addresses 0..ROWS-1. Each word is serialized LSB-first, one pixel per accepted beat, with start-of-line, end-of-line and end-of-frame markers. The block sits downstream of the filter's RAM write port, on the read side of the same RAM, and feeds display, UART or checker logic.

## Interface
- WIDTH, 64, pixels per row (RAM word width)
- ROWS, 49, rows per frame (RAM addresses 0..ROWS-1)
- ADDR_W, 7, RAM address width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  pulse, begins one frame read; honoured only in IDLE
- ramdata  in  WIDTH  RAM read data, valid the cycle after read_request
- ramaddress  out  ADDR_W  RAM read address
- read_request  out  1  RAM read strobe, one cycle per row
- pix_valid  out  1  pix_data/markers valid
- pix_ready  in  1  sink accepts beat when pix_valid & pix_ready
- pix_data  out  1  current pixel
- sol  out  1  beat is column 0
- eol  out  1  beat is column WIDTH-1
- eof  out  1  beat is last pixel of row ROWS-1
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after last beat of frame

## Operation
- FSM states: IDLE, REQ, LOAD, SHIFT, DONE.
- IDLE: on start=1, clear row to 0 and go to REQ.
- REQ: read_request=1 and ramaddress=row, then go to LOAD.
- LOAD: capture ramdata into the shift register, clear col to 0, then go to SHIFT.
- SHIFT:
  - pix_valid=1 and pix_data=shreg[0].
  - sol = (col==0); eol = (col==WIDTH-1); eof = eol & (row==ROWS-1).
  - On handshake: shift right by 1 and increment col.
  - On handshake at col==WIDTH-1: if row==ROWS-1, go to DONE; otherwise increment row and go to REQ.
- DONE: done=1 for one cycle, then go to IDLE.
- start is ignored while busy and in the DONE cycle.
- Data and marker outputs hold stable while pix_valid=1 and pix_ready=0; no beat is dropped or duplicated.
- Counters:
  - col is log2(WIDTH) bits.
  - row is ADDR_W bits.
  - Neither counter wraps mid-frame; the terminal compares above end the frame.

## Timing
- Reset values: ramaddress=0, read_request=0, pix_valid=0, pix_data=0, sol=0, eol=0, eof=0, busy=0, done=0. FSM goes to IDLE and the shift register is cleared.
- Reset asserted mid-frame aborts the frame on the next edge. No done pulse is produced, and the next start begins again at row 0.
- RAM read latency is exactly 1 cycle: ramdata is sampled in LOAD, the cycle after REQ.
- start at edge N gives read_request at N+1 and the first pix_valid at N+3.
- With pix_ready held at 1:
  - each row takes WIDTH+2 cycles;
  - a frame takes ROWS*(WIDTH+2) cycles plus 1 IDLE→REQ cycle plus 1 DONE cycle;
  - pix_valid drops for exactly 2 cycles (REQ, LOAD) between rows.
- The done pulse occurs in the cycle after the handshake of the eof beat.
- pix_ready may toggle arbitrarily. pix_valid never depends combinationally on pix_ready.

## Structure
- Shared package image_pkg holds:
  - constants IMG_WIDTH=64, IMG_ROWS=49, IMG_ADDR_W=7;
  - the state enum typedef rd_state_t, also used by the filter's controller.
- Sub-module row_serializer:
  - contains the shift register and the col counter;
  - inputs: load, word, ready;
  - outputs: pix_data, sol, eol, last_beat.
- The top level holds the FSM, the row counter and the RAM-side outputs.

## Test plan
- Reset values: hold rst=0 for 3 cycles with start=1 → every output 0, no read_request.
- Single frame with pix_ready=1; RAM word at address a = {57'b0, a[6:0]} → 49 read_requests at addresses 0..48.
  - Row a emits bits 0..6 equal to a, followed by zeros.
  - 49×64 = 3136 beats, 49 sol and 49 eol pulses, a single eof on beat 3136.
  - done one cycle later; total 3236 cycles.
- Backpressure: random pix_ready at 30% duty → the received bit stream is identical to the pix_ready=1 run, and outputs stay stable on every stalled cycle.
- Start while busy: pulse start mid-row 10 → no restart, row/col sequence unaffected, exactly one done.
- Reset mid-frame: rst=0 during row 20, col 33, then start → no done from the aborted frame; the new frame's first read_request is at address 0 and its first beat has sol=1.
- Small parameters: WIDTH=8, ROWS=2 with RAM words 0xA5 and 0x3C → stream 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0; eof on beat 16.
